// File: rtl/rv_dp.sv
// rv_dp: datapath of the multicycle RISC-V core.
// Holds PC, PCC, IR, MDR, ALUOut and the register file, and contains the
// immediate generator, the ALU and the operand/writeback/address muxes.
// The control FSM drives every select and enable below each cycle.
module rv_dp #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcsourse,
    input  logic        pcwrite,
    input  logic        pccen,
    input  logic        irwrite,
    input  logic [1:0]  wbsel,
    input  logic        regwen,
    input  logic [1:0]  immsel,
    input  logic [1:0]  asel,
    input  logic [1:0]  bsel,
    input  logic [3:0]  alusel,
    input  logic        mdrwrite,
    input  logic        memrw,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic        zero,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [31:0] pc
);

    localparam logic       PC_INC        = 1'b0;
    localparam logic       PC_ALU        = 1'b1;
    localparam logic [1:0] WB_PC         = 2'd0;
    localparam logic [1:0] WB_ALUOUT     = 2'd1;
    localparam logic [1:0] WB_MDR        = 2'd2;
    localparam logic [1:0] WB_ADDI       = 2'd3;
    localparam logic [1:0] IMM_L         = 2'd0;
    localparam logic [1:0] IMM_S         = 2'd1;
    localparam logic [1:0] IMM_B         = 2'd2;
    localparam logic [1:0] IMM_J         = 2'd3;
    localparam logic [1:0] ALUA_REG      = 2'd0;
    localparam logic [1:0] ALUA_PCC      = 2'd1;
    localparam logic [1:0] ALUA_ADD      = 2'd2;
    localparam logic [1:0] ALUB_REG      = 2'd0;
    localparam logic [1:0] ALUB_IMM      = 2'd1;
    localparam logic [1:0] ALUB_CONSTXOR = 2'd2;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1110;

    // 32-bit wrap-around ALU; shift amount is b[4:0], unknown codes give 0
    function automatic logic [31:0] alu_f(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  op);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [4:0]         sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        case (op)
            ALU_ADD:  alu_f = a + b;
            ALU_SUB:  alu_f = a - b;
            ALU_SLL:  alu_f = a << sh;
            ALU_SLT:  alu_f = {31'd0, (sa < sb)};
            ALU_SLTU: alu_f = {31'd0, (a < b)};
            ALU_XOR:  alu_f = a ^ b;
            ALU_SRL:  alu_f = a >> sh;
            ALU_SRA:  alu_f = sa >>> sh;
            ALU_OR:   alu_f = a | b;
            ALU_AND:  alu_f = a & b;
            default:  alu_f = 32'd0;
        endcase
    endfunction

    logic [31:0] pc_q, pc_d;
    logic [31:0] pcc_q, pcc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_res, wb_data;

    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign rd  = ir_q[11:7];

    // register-file reads are combinational; x0 is hard-wired to zero
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

    // immediate generator, sign-extended from IR[31]
    always_comb begin
        imm = 32'd0;
        case (immsel)
            IMM_L: imm = {{20{ir_q[31]}}, ir_q[31:20]};
            IMM_S: imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMM_B: imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_J: imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

    // ALU operand muxes, ALU and writeback source select
    always_comb begin
        alu_a = 32'd0;
        case (asel)
            ALUA_REG: alu_a = rs1_val;
            ALUA_PCC: alu_a = pcc_q;
            ALUA_ADD: alu_a = aluout_q;
            default:  alu_a = 32'd0;
        endcase
        alu_b = 32'd0;
        case (bsel)
            ALUB_REG:      alu_b = rs2_val;
            ALUB_IMM:      alu_b = imm;
            ALUB_CONSTXOR: alu_b = 32'd0;
            default:       alu_b = 32'd0;
        endcase
        alu_res = alu_f(alu_a, alu_b, alusel);
        wb_data = pc_q;
        case (wbsel)
            WB_PC:     wb_data = pc_q;
            WB_ALUOUT: wb_data = aluout_q;
            WB_MDR:    wb_data = mdr_q;
            WB_ADDI:   wb_data = alu_res;
            default:   wb_data = pc_q;
        endcase
    end

    // next-state of all architectural and inter-cycle registers; every
    // source is a current-cycle value, so simultaneous updates see old state
    always_comb begin
        pc_d = pc_q;
        if (pcwrite) begin
            pc_d = (pcsourse == PC_INC) ? (pc_q + 32'd4) : aluout_q;
        end
        pcc_d    = pccen    ? pc_q      : pcc_q;
        ir_d     = irwrite  ? mem_rdata : ir_q;
        mdr_d    = mdrwrite ? mem_rdata : mdr_q;
        aluout_d = alu_res;
        rf_d     = rf_q;
        if (regwen && (rd != 5'd0)) begin
            rf_d[rd] = wb_data;
        end
    end

    // state registers; reset overrides every enable
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            pcc_q    <= 32'd0;
            ir_q     <= 32'd0;
            mdr_q    <= 32'd0;
            aluout_q <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else begin
            pc_q     <= pc_d;
            pcc_q    <= pcc_d;
            ir_q     <= ir_d;
            mdr_q    <= mdr_d;
            aluout_q <= aluout_d;
            rf_q     <= rf_d;
        end
    end

    assign instr     = ir_q;
    assign zero      = (alu_res == 32'd0);
    assign mem_addr  = irwrite ? pc_q : aluout_q;
    assign mem_wdata = rs2_val;
    assign mem_we    = memrw;
    assign pc        = pc_q;

endmodule
